raster_cmd_assembler: RTL and testbench

//  Sits directly downstream of the AXI-Stream deserializer in raster-core.

---
 rtl/raster_cmd_assembler_pkg.sv | 25 ++
 rtl/raster_cmd_assembler_if.sv | 26 ++
 rtl/raster_cmd_assembler.sv | 125 ++++++++++++
 tb/tb_raster_cmd_assembler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_cmd_assembler_pkg.sv
// Shared constants for the raster command assembler: default geometry, FSM encoding
// and word offsets of the triangle fields inside an assembled command.
package raster_cmd_assembler_pkg;

    localparam int unsigned RC_DATA_W        = 32;
    localparam int unsigned RC_WORDS_PER_CMD = 9;
    localparam int unsigned RC_CNT_W         = 16;
    localparam int unsigned RC_CMD_W         = RC_DATA_W * RC_WORDS_PER_CMD;

    localparam logic [1:0] StCollect = 2'd0;
    localparam logic [1:0] StHold    = 2'd1;
    localparam logic [1:0] StDrain   = 2'd2;

    // Word index of each triangle field; vertex n occupies words 3n..3n+2.
    localparam int unsigned V0_X = 0;
    localparam int unsigned V0_Y = 1;
    localparam int unsigned V0_A = 2;
    localparam int unsigned V1_X = 3;
    localparam int unsigned V1_Y = 4;
    localparam int unsigned V1_A = 5;
    localparam int unsigned V2_X = 6;
    localparam int unsigned V2_Y = 7;
    localparam int unsigned V2_A = 8;

endpackage

// File: rtl/raster_cmd_assembler_if.sv
// Word-stream input and command output handshakes of the assembler.
// master: deserializer plus raster core side; slave: the assembler.
interface raster_cmd_assembler_if
    import raster_cmd_assembler_pkg::*;
#(
    parameter int unsigned DATA_W = RC_DATA_W,
    parameter int unsigned CMD_W  = RC_CMD_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [CMD_W-1:0]  m_cmd;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_cmd
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_cmd
    );
endinterface

// File: rtl/raster_cmd_assembler.sv
// Packs WORDS_PER_CMD stream words of one TLAST-delimited packet into one wide triangle
// command; short and long packets are dropped and counted instead of being forwarded.
module raster_cmd_assembler
    import raster_cmd_assembler_pkg::*;
#(
    parameter int unsigned DATA_W        = RC_DATA_W,
    parameter int unsigned WORDS_PER_CMD = RC_WORDS_PER_CMD,
    parameter int unsigned CNT_W         = RC_CNT_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    raster_cmd_assembler_if.slave bus,
    output logic                 err_short,
    output logic                 err_long,
    output logic [CNT_W-1:0]     cmd_count,
    output logic [CNT_W-1:0]     err_count
);
    localparam int unsigned CMD_W = DATA_W * WORDS_PER_CMD;
    localparam int unsigned IDX_W = $clog2(WORDS_PER_CMD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_CMD - 1);

    if (WORDS_PER_CMD < 2 || WORDS_PER_CMD > 64) begin : g_bad_words_per_cmd
        $error("raster_cmd_assembler: WORDS_PER_CMD must be in 2..64");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CMD_W-1:0] shadow_q, shadow_d;
    logic [CMD_W-1:0] m_cmd_q, m_cmd_d;
    logic             s_ready_q, m_valid_q;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             in_hs, out_hs;

    assign in_hs  = bus.s_valid && s_ready_q;
    assign out_hs = m_valid_q && bus.m_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        m_cmd_d     = m_cmd_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;
        case (state_q)
            StCollect: begin
                if (in_hs) begin
                    shadow_d[int'(idx_q)*DATA_W +: DATA_W] = bus.s_data;
                    idx_d = '0;
                    if (idx_q == LAST_IDX) begin
                        if (bus.s_last) begin
                            // m_cmd only ever changes here, so dropped packets never reach it
                            state_d = StHold;
                            m_cmd_d = shadow_d;
                        end else begin
                            state_d     = StDrain;
                            err_long_d  = 1'b1;
                            err_count_d = sat_inc(err_count_q);
                        end
                    end else if (bus.s_last) begin
                        err_short_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (out_hs) begin
                    state_d     = StCollect;
                    cmd_count_d = cmd_count_q + 1'b1;
                end
            end
            StDrain: begin
                if (in_hs && bus.s_last) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= StCollect;
            idx_q       <= '0;
            shadow_q    <= '0;
            m_cmd_q     <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            m_cmd_q     <= m_cmd_d;
            s_ready_q   <= (state_d != StHold);
            m_valid_q   <= (state_d == StHold);
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_cmd   = m_cmd_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign cmd_count   = cmd_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_raster_cmd_assembler.sv
// Self-checking bench for raster_cmd_assembler: scoreboard of expected commands,
// table of packet shapes with expected outcomes, and hand-written reset/backpressure cases.
`timescale 1ns/1ps
module tb_raster_cmd_assembler;
    import raster_cmd_assembler_pkg::*;

    localparam int unsigned DW       = RC_DATA_W;
    localparam int unsigned WPC      = RC_WORDS_PER_CMD;
    localparam int unsigned CW       = DW * WPC;
    localparam int unsigned TB_CNT_W = 8;  // narrow counters so wrap/saturation fit the run

    typedef logic [CW-1:0] cmd_t;
    typedef struct {
        int n_words;
        int gap_max;
        int exp_cmd;
        int exp_short;
        int exp_long;
    } vec_t;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                err_short, err_long;
    logic [TB_CNT_W-1:0] cmd_count, err_count;
    logic                ready_fixed = 1'b1;
    logic                rand_ready = 1'b0;
    logic                rnd_bit = 1'b1;

    raster_cmd_assembler_if bus ();

    raster_cmd_assembler #(
        .CNT_W(TB_CNT_W)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .err_short(err_short),
        .err_long (err_long),
        .cmd_count(cmd_count),
        .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    assign bus.m_ready = rand_ready ? rnd_bit : ready_fixed;

    always begin
        @(posedge aclk);
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_short_seen = 0;
    int   n_long_seen = 0;
    int   n_cmd_seen = 0;
    int   pkt_tag = 0;
    int   exp_err = 0;
    int   exp_cmd_total = 0;
    cmd_t sb_q[$];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic check_cmd(input string what, input cmd_t act, input cmd_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", what, act, exp);
        end
    endtask

    // Output monitor: every valid cycle must show the scoreboard head and keep s_ready low.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (err_short) n_short_seen++;
            if (err_long) n_long_seen++;
            if (bus.m_valid) begin
                check("s_ready while holding", 32'(bus.s_ready), 32'd0);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected command: got 0x%h, expected none", bus.m_cmd);
                end else begin
                    check_cmd("m_cmd vs scoreboard", bus.m_cmd, sb_q[0]);
                    if (bus.m_ready) begin
                        void'(sb_q.pop_front());
                        n_cmd_seen++;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int   guard;
        logic hs;
        guard = 0;
        hs = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        do begin
            @(negedge aclk);
            hs = bus.s_ready;
            @(posedge aclk);
            #1;
            guard++;
        end while (!hs && guard < 1000);
        if (!hs) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready timeout: got 0, expected 1 within 1000 cycles");
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_packet(input int n, input int gap_max, input bit expect_cmd);
        cmd_t            c;
        logic [DW-1:0]   w;
        logic [15:0]     tag;
        logic [15:0]     ix;
        c = '0;
        pkt_tag++;
        tag = pkt_tag[15:0];
        for (int i = 0; i < n; i++) begin
            ix = i[15:0];
            w  = {tag, ix};
            if (i < int'(WPC)) c[i*DW +: DW] = w;
        end
        if (expect_cmd) sb_q.push_back(c);
        for (int i = 0; i < n; i++) begin
            ix = i[15:0];
            send_word({tag, ix}, (i == n - 1));
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge aclk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 2000) begin
            @(negedge aclk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain timeout: got %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge aclk);
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"}, 32'(bus.s_ready), 32'd0);
        check({tag, " m_valid"}, 32'(bus.m_valid), 32'd0);
        check_cmd({tag, " m_cmd"}, bus.m_cmd, '0);
        check({tag, " err pulses"}, {30'd0, err_short, err_long}, 32'd0);
        check({tag, " cmd_count"}, 32'(cmd_count), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        int s0, l0, c0;
        vecs = '{
            '{9, 0, 1, 0, 0},
            '{4, 0, 0, 1, 0},
            '{9, 0, 1, 0, 0},
            '{12, 0, 0, 0, 1},
            '{9, 2, 1, 0, 0},
            '{1, 0, 0, 1, 0},
            '{8, 1, 0, 1, 0},
            '{10, 0, 0, 0, 1},
            '{2, 0, 0, 1, 0},
            '{18, 3, 0, 0, 1},
            '{9, 0, 1, 0, 0}
        };
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("reset");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Test 1: words 1..9, m_valid one cycle after the final handshake
        for (int i = 1; i <= 9; i++) begin
            logic [DW-1:0] w1;
            w1 = DW'(i);
            if (i == 1) sb_q.push_back(cmd_t'(288'h00000009_00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001));
            send_word(w1, (i == 9));
        end
        check("t1 m_valid latency", 32'(bus.m_valid), 32'd1);
        @(posedge aclk);
        #1;
        check("t1 cmd_count", 32'(cmd_count), 32'd1);
        check("t1 m_valid dropped", 32'(bus.m_valid), 32'd0);
        check("t1 no error pulses", 32'(n_short_seen + n_long_seen), 32'd0);
        exp_cmd_total = 1;

        // Test 2: backpressure holds the command, then release
        ready_fixed = 1'b0;
        send_packet(WPC, 0, 1'b1);
        repeat (5) begin
            @(negedge aclk);
            check("t2 m_valid held", 32'(bus.m_valid), 32'd1);
        end
        @(posedge aclk);
        #1;
        ready_fixed = 1'b1;
        @(posedge aclk);
        #1;
        check("t2 s_ready after accept", 32'(bus.s_ready), 32'd1);
        check("t2 m_valid after accept", 32'(bus.m_valid), 32'd0);
        exp_cmd_total++;
        wait_idle();
        check("t2 cmd_count", 32'(cmd_count), 32'(exp_cmd_total));

        // Table of packet shapes
        for (int v = 0; v < 11; v++) begin
            s0 = n_short_seen;
            l0 = n_long_seen;
            c0 = n_cmd_seen;
            send_packet(vecs[v].n_words, vecs[v].gap_max, vecs[v].exp_cmd != 0);
            wait_idle();
            exp_err = exp_err + vecs[v].exp_short + vecs[v].exp_long;
            if (exp_err > 255) exp_err = 255;
            exp_cmd_total = exp_cmd_total + vecs[v].exp_cmd;
            check($sformatf("vec%0d err_short pulses", v), 32'(n_short_seen - s0), 32'(vecs[v].exp_short));
            check($sformatf("vec%0d err_long pulses", v), 32'(n_long_seen - l0), 32'(vecs[v].exp_long));
            check($sformatf("vec%0d commands", v), 32'(n_cmd_seen - c0), 32'(vecs[v].exp_cmd));
            check($sformatf("vec%0d err_count", v), 32'(err_count), 32'(exp_err));
            check($sformatf("vec%0d cmd_count", v), 32'(cmd_count), 32'(exp_cmd_total % 256));
        end

        // Test 5: reset after 5 words; the 4-word tail is a short packet
        pkt_tag++;
        for (int i = 0; i < 5; i++) send_word(DW'(32'hA500 + i), 1'b0);
        aresetn = 1'b0;
        @(posedge aclk);
        repeat (2) begin
            @(negedge aclk);
            check_reset_outputs("t5 in reset");
            @(posedge aclk);
        end
        #1;
        aresetn = 1'b1;
        sb_q.delete();
        exp_err = 0;
        exp_cmd_total = 0;
        @(negedge aclk);
        check("t5 s_ready first cycle", 32'(bus.s_ready), 32'd0);
        @(negedge aclk);
        check("t5 s_ready second cycle", 32'(bus.s_ready), 32'd1);
        @(posedge aclk);
        #1;
        s0 = n_short_seen;
        c0 = n_cmd_seen;
        for (int i = 5; i < 9; i++) send_word(DW'(32'hA500 + i), (i == 8));
        send_packet(WPC, 0, 1'b1);
        wait_idle();
        exp_err = 1;
        exp_cmd_total = 1;
        check("t5 tail err_short", 32'(n_short_seen - s0), 32'd1);
        check("t5 err_count", 32'(err_count), 32'd1);
        check("t5 command out", 32'(n_cmd_seen - c0), 32'd1);
        check("t5 cmd_count", 32'(cmd_count), 32'd1);

        // err_count saturation with one-word packets
        s0 = n_short_seen;
        for (int k = 0; k < 260; k++) send_packet(1, 0, 1'b0);
        wait_idle();
        check("sat err_short pulses", 32'(n_short_seen - s0), 32'd260);
        check("sat err_count", 32'(err_count), 32'd255);
        check("sat cmd_count", 32'(cmd_count), 32'd1);

        // Test 6: long random-gap run, cmd_count wraps
        c0 = n_cmd_seen;
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) send_packet(WPC, 2, 1'b1);
        wait_idle();
        rand_ready = 1'b0;
        exp_cmd_total = exp_cmd_total + 300;
        check("t6 commands", 32'(n_cmd_seen - c0), 32'd300);
        check("t6 cmd_count wrap", 32'(cmd_count), 32'(exp_cmd_total % 256));
        check("t6 err_count", 32'(err_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
